// File: rtl/axis_flit_egress_bridge_if.sv
// AXI4-Stream bundle used on the egress side of the flit bridge.
// Signals: tdata/tstrb/tkeep/tlast/tid/tdest/tuser/tvalid driven by the master,
// tready driven by the slave.
// Modports: master (bridge side), slave (endpoint side).
interface axis_flit_egress_bridge_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ID_W   = 8,
    parameter int unsigned DEST_W = 4,
    parameter int unsigned USER_W = 8
);
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tstrb;
    logic [DATA_W/8-1:0] tkeep;
    logic                tlast;
    logic [ID_W-1:0]     tid;
    logic [DEST_W-1:0]   tdest;
    logic [USER_W-1:0]   tuser;
    logic                tvalid;
    logic                tready;

    modport master (
        output tdata, tstrb, tkeep, tlast, tid, tdest, tuser, tvalid,
        input  tready
    );

    modport slave (
        input  tdata, tstrb, tkeep, tlast, tid, tdest, tuser, tvalid,
        output tready
    );
endinterface

// File: rtl/axis_flit_egress_bridge.sv
// Egress bridge: OutPortSimple flits -> AXI4-Stream master.
// A DEPTH-entry FIFO decouples the flit side from the stream side (1 beat/cycle,
// no fall-through). Optional store-and-forward mode holds tvalid until a whole
// tlast-terminated packet is buffered, with a forced release when the FIFO fills.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   get_flit_i          {valid, tail, dst, vc, data}; data = {tlast,tkeep,tstrb,tdata,tdest,tuser,tid}
//   get_flit_valid_i    flit offered
//   get_flit_ready_o    flit accepted this cycle (depends only on registered state)
//   axis                AXI4-Stream master
//   occupancy_o         FIFO entries held
//   pkt_count_o         tlast beats delivered (wraps)
//   drop_count_o        accepted flits whose embedded valid bit was 0 (wraps)
module axis_flit_egress_bridge #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned ID_W      = 8,
    parameter int unsigned DEST_W    = 4,
    parameter int unsigned USER_W    = 8,
    parameter int unsigned DEST_BITS = 4,
    parameter int unsigned VC_BITS   = 2,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned PKT_MODE  = 0,
    parameter int unsigned CNT_W     = 16,
    localparam int unsigned STRB_W   = DATA_W / 8,
    localparam int unsigned FD_W     = 1 + 2 * STRB_W + DATA_W + DEST_W + USER_W + ID_W,
    localparam int unsigned FLIT_W   = FD_W + 2 + DEST_BITS + VC_BITS,
    localparam int unsigned PTR_W    = $clog2(DEPTH),
    localparam int unsigned OCC_W    = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [FLIT_W-1:0]  get_flit_i,
    input  logic               get_flit_valid_i,
    output logic               get_flit_ready_o,
    axis_flit_egress_bridge_if.master axis,
    output logic [OCC_W-1:0]   occupancy_o,
    output logic [CNT_W-1:0]   pkt_count_o,
    output logic [CNT_W-1:0]   drop_count_o
);

    localparam logic [OCC_W-1:0] Full = OCC_W'(DEPTH);

    logic [FD_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [CNT_W-1:0] pkt_cnt_q, drop_cnt_q;
    logic             live_q;
    logic             ready, accept, push, drop, pop, tvalid, head_last;
    logic [FD_W-1:0]  head;

    // Tail/dst/vc routing fields carry no meaning downstream.
    logic unused_flit_fields;
    assign unused_flit_fields = ^get_flit_i[FLIT_W-2:FD_W];

    // live_q keeps ready low while in reset and for the release edge.
    assign ready  = live_q && (occ_q != Full);
    assign accept = get_flit_valid_i && ready;
    assign push   = accept && get_flit_i[FLIT_W-1];
    assign drop   = accept && !get_flit_i[FLIT_W-1];

    assign head      = mem_q[rd_ptr_q];
    assign head_last = head[FD_W-1];
    assign pop       = tvalid && axis.tready;

    assign {axis.tlast, axis.tkeep, axis.tstrb, axis.tdata,
            axis.tdest, axis.tuser, axis.tid} = head;
    assign axis.tvalid = tvalid;

    assign get_flit_ready_o = ready;
    assign occupancy_o      = occ_q;
    assign pkt_count_o      = pkt_cnt_q;
    assign drop_count_o     = drop_cnt_q;

    always_comb begin
        occ_d = occ_q;
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    // Storage needs no reset: pointers and occupancy define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= get_flit_i[FD_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
            live_q     <= 1'b0;
        end else begin
            live_q <= 1'b1;
            occ_q  <= occ_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (pop && head_last) pkt_cnt_q <= pkt_cnt_q + 1'b1;
            if (drop) drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    if (PKT_MODE != 0) begin : g_pkt
        typedef enum logic {StHold, StSend} state_e;

        state_e           state_q, state_d;
        logic [OCC_W-1:0] lcnt_q, lcnt_d;
        logic             push_last, pop_last;

        assign push_last = push && get_flit_i[FD_W-1];
        assign pop_last  = pop && head_last;

        // Count of complete packets (tlast beats) currently buffered.
        always_comb begin
            lcnt_d = lcnt_q;
            unique case ({push_last, pop_last})
                2'b10:   lcnt_d = lcnt_q + 1'b1;
                2'b01:   lcnt_d = lcnt_q - 1'b1;
                default: lcnt_d = lcnt_q;
            endcase
        end

        // Kept out of the next-state block: pop depends on tvalid.
        assign tvalid = (state_q == StSend) && (occ_q != '0);

        always_comb begin
            state_d = state_q;
            unique case (state_q)
                StHold: begin
                    // A full FIFO forces release so over-long packets cannot deadlock.
                    if (lcnt_q != '0 || occ_q == Full) state_d = StSend;
                end
                StSend: begin
                    if (pop_last && lcnt_d == '0 && occ_d != Full) state_d = StHold;
                end
                default: state_d = StHold;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= StHold;
                lcnt_q  <= '0;
            end else begin
                state_q <= state_d;
                lcnt_q  <= lcnt_d;
            end
        end
    end else begin : g_ct
        assign tvalid = (occ_q != '0);
    end

endmodule

// File: tb/tb_axis_flit_egress_bridge.sv
module tb_axis_flit_egress_bridge;
    localparam int DATA_W    = 64;
    localparam int ID_W      = 8;
    localparam int DEST_W    = 4;
    localparam int USER_W    = 8;
    localparam int DEST_BITS = 4;
    localparam int VC_BITS   = 2;
    localparam int DEPTH     = 4;
    localparam int CNT_W     = 16;
    localparam int FD_W      = 1 + 2 * (DATA_W / 8) + DATA_W + DEST_W + USER_W + ID_W;
    localparam int FLIT_W    = FD_W + 2 + DEST_BITS + VC_BITS;
    localparam int OCC_W     = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [FLIT_W-1:0] flit_ct, flit_pk;
    logic              fv_ct, fv_pk, tr_ct, tr_pk;
    logic              rdy_ct, rdy_pk;
    logic [OCC_W-1:0]  occ_ct, occ_pk;
    logic [CNT_W-1:0]  pkt_ct, pkt_pk, drp_ct, drp_pk;

    axis_flit_egress_bridge_if #(.DATA_W(DATA_W), .ID_W(ID_W), .DEST_W(DEST_W),
                                 .USER_W(USER_W)) ax_ct ();
    axis_flit_egress_bridge_if #(.DATA_W(DATA_W), .ID_W(ID_W), .DEST_W(DEST_W),
                                 .USER_W(USER_W)) ax_pk ();
    assign ax_ct.tready = tr_ct;
    assign ax_pk.tready = tr_pk;

    axis_flit_egress_bridge #(
        .DATA_W(DATA_W), .ID_W(ID_W), .DEST_W(DEST_W), .USER_W(USER_W),
        .DEST_BITS(DEST_BITS), .VC_BITS(VC_BITS), .DEPTH(DEPTH), .PKT_MODE(0), .CNT_W(CNT_W)
    ) u_ct (
        .clk(clk), .rst_n(rst_n), .get_flit_i(flit_ct), .get_flit_valid_i(fv_ct),
        .get_flit_ready_o(rdy_ct), .axis(ax_ct), .occupancy_o(occ_ct),
        .pkt_count_o(pkt_ct), .drop_count_o(drp_ct)
    );

    axis_flit_egress_bridge #(
        .DATA_W(DATA_W), .ID_W(ID_W), .DEST_W(DEST_W), .USER_W(USER_W),
        .DEST_BITS(DEST_BITS), .VC_BITS(VC_BITS), .DEPTH(DEPTH), .PKT_MODE(1), .CNT_W(CNT_W)
    ) u_pk (
        .clk(clk), .rst_n(rst_n), .get_flit_i(flit_pk), .get_flit_valid_i(fv_pk),
        .get_flit_ready_o(rdy_pk), .axis(ax_pk), .occupancy_o(occ_pk),
        .pkt_count_o(pkt_pk), .drop_count_o(drp_pk)
    );

    logic [FD_W-1:0] q_ct[$];
    logic [FD_W-1:0] q_pk[$];
    int checks = 0;
    int passes = 0;
    int beats_ct = 0;
    int beats_pk = 0;

    // Data field {tlast,tkeep,tstrb,tdata,tdest,tuser,tid} derived from a tag.
    function automatic logic [FD_W-1:0] mk(input logic [15:0] tag, input logic last);
        return {last, 8'hff, tag[7:0], tag, ~tag, tag, 16'hc0de,
                tag[3:0], tag[15:8], tag[7:0] ^ 8'h5a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Scoreboard monitors: compare every fired beat against the queue head.
    always @(negedge clk) begin
        if (rst_n && ax_ct.tvalid && ax_ct.tready) begin
            logic [FD_W-1:0] got, exp;
            got = {ax_ct.tlast, ax_ct.tkeep, ax_ct.tstrb, ax_ct.tdata,
                   ax_ct.tdest, ax_ct.tuser, ax_ct.tid};
            checks++;
            beats_ct++;
            if (q_ct.size() == 0) begin
                $display("FAIL ct_beat: got %h expected no beat", got);
            end else begin
                exp = q_ct.pop_front();
                if (got === exp) passes++;
                else $display("FAIL ct_beat: got %h expected %h", got, exp);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ax_pk.tvalid && ax_pk.tready) begin
            logic [FD_W-1:0] got, exp;
            got = {ax_pk.tlast, ax_pk.tkeep, ax_pk.tstrb, ax_pk.tdata,
                   ax_pk.tdest, ax_pk.tuser, ax_pk.tid};
            checks++;
            beats_pk++;
            if (q_pk.size() == 0) begin
                $display("FAIL pk_beat: got %h expected no beat", got);
            end else begin
                exp = q_pk.pop_front();
                if (got === exp) passes++;
                else $display("FAIL pk_beat: got %h expected %h", got, exp);
            end
        end
    end

    // Offer one flit, hold it until accepted (bounded), return #1 after the accept edge.
    task automatic send(input bit pk, input bit vb, input logic last, input logic [15:0] tag);
        logic [FD_W-1:0] fd;
        bit ok;
        fd = mk(tag, last);
        ok = 1'b0;
        if (pk) begin flit_pk = {vb, last, 4'(tag), 2'(tag), fd}; fv_pk = 1'b1; end
        else    begin flit_ct = {vb, last, 4'(tag), 2'(tag), fd}; fv_ct = 1'b1; end
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (pk ? rdy_pk : rdy_ct) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            if (vb) begin
                if (pk) q_pk.push_back(fd);
                else    q_ct.push_back(fd);
            end
            @(posedge clk);
        end else begin
            checks++;
            $display("FAIL send_timeout: tag %0h got no ready expected ready within 60 cycles", tag);
        end
        #1;
        if (pk) fv_pk = 1'b0;
        else    fv_ct = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        fv_ct = 1'b0; fv_pk = 1'b0; tr_ct = 1'b0; tr_pk = 1'b0;
        flit_ct = '0; flit_pk = '0;

        // Reset state
        idle(3);
        chk("rst_occ", 64'(occ_ct), 0);
        chk("rst_tvalid", 64'(ax_ct.tvalid), 0);
        chk("rst_ready", 64'(rdy_ct), 0);
        chk("rst_pk_tvalid", 64'(ax_pk.tvalid), 0);
        rst_n = 1'b1;
        idle(1);
        chk("ready_after_rst", 64'(rdy_ct), 1);

        // T1 cut-through, back-to-back
        tr_ct = 1'b1;
        send(0, 1, 0, 16'h0001);
        chk("t1_latency", 64'(ax_ct.tvalid), 1);
        for (int i = 2; i <= 8; i++) send(0, 1, (i == 4 || i == 8), 16'(i));
        idle(1);
        chk("t1_beats", 64'(beats_ct), 8);
        chk("t1_pkts", 64'(pkt_ct), 2);
        chk("t1_occ", 64'(occ_ct), 0);

        // T2 backpressure
        tr_ct = 1'b0;
        for (int i = 1; i <= 4; i++) send(0, 1, 0, 16'h0020 + 16'(i));
        chk("t2_occ_full", 64'(occ_ct), 4);
        chk("t2_ready_full", 64'(rdy_ct), 0);
        chk("t2_tvalid", 64'(ax_ct.tvalid), 1);
        fork
            begin
                send(0, 1, 0, 16'h0025);
                send(0, 1, 1, 16'h0026);
            end
            begin
                idle(3);
                tr_ct = 1'b1;
            end
        join
        idle(6);
        chk("t2_beats", 64'(beats_ct), 14);
        chk("t2_pkts", 64'(pkt_ct), 3);
        chk("t2_occ", 64'(occ_ct), 0);
        chk("t2_sb_empty", 64'(q_ct.size()), 0);

        // T3 drops
        for (int i = 0; i < 10; i++)
            send(0, !(i == 2 || i == 5 || i == 8), (i == 9), 16'h0030 + 16'(i));
        idle(3);
        chk("t3_drops", 64'(drp_ct), 3);
        chk("t3_beats", 64'(beats_ct), 21);
        chk("t3_pkts", 64'(pkt_ct), 4);

        // T4 store-and-forward, gapped packet
        tr_pk = 1'b1;
        send(1, 1, 0, 16'h0041);
        idle(2);
        chk("t4_hold1", 64'(ax_pk.tvalid), 0);
        chk("t4_occ1", 64'(occ_pk), 1);
        send(1, 1, 0, 16'h0042);
        idle(2);
        chk("t4_hold2", 64'(ax_pk.tvalid), 0);
        chk("t4_occ2", 64'(occ_pk), 2);
        send(1, 1, 1, 16'h0043);
        seen = 1'b0;
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            if (ax_pk.tvalid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t4_release", 64'(seen), 1);
        @(negedge clk);
        chk("t4_contig2", 64'(ax_pk.tvalid), 1);
        @(negedge clk);
        chk("t4_contig3", 64'(ax_pk.tvalid), 1);
        @(negedge clk);
        chk("t4_done", 64'(ax_pk.tvalid), 0);
        idle(1);
        chk("t4_beats", 64'(beats_pk), 3);
        chk("t4_pkts", 64'(pkt_pk), 1);

        // T5 forced release on full FIFO
        for (int i = 1; i <= 4; i++) send(1, 1, 0, 16'h0050 + 16'(i));
        chk("t5_occ_full", 64'(occ_pk), 4);
        chk("t5_ready_full", 64'(rdy_pk), 0);
        send(1, 1, 0, 16'h0055);
        send(1, 1, 1, 16'h0056);
        idle(8);
        chk("t5_beats", 64'(beats_pk), 9);
        chk("t5_pkts", 64'(pkt_pk), 2);
        chk("t5_occ", 64'(occ_pk), 0);
        chk("t5_sb_empty", 64'(q_pk.size()), 0);

        // T6 async reset mid-packet
        tr_ct = 1'b0;
        for (int i = 1; i <= 3; i++) send(0, 1, 0, 16'h0060 + 16'(i));
        chk("t6_occ_pre", 64'(occ_ct), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_tvalid", 64'(ax_ct.tvalid), 0);
        chk("t6_occ", 64'(occ_ct), 0);
        chk("t6_pkts", 64'(pkt_ct), 0);
        chk("t6_drops", 64'(drp_ct), 0);
        chk("t6_ready", 64'(rdy_ct), 0);
        q_ct.delete();
        q_pk.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        tr_ct = 1'b1;
        send(0, 1, 0, 16'h0071);
        send(0, 1, 1, 16'h0072);
        idle(3);
        chk("t6_post_beats", 64'(beats_ct), 23);
        chk("t6_post_pkts", 64'(pkt_ct), 1);
        chk("t6_post_occ", 64'(occ_ct), 0);
        chk("t6_sb_empty", 64'(q_ct.size()), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
